// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default
// frame parameters, imported by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned DEF_DBITS      = 8;
  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_SB_TICK    = 16;
  localparam int unsigned DEF_PARITY     = PAR_NONE;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBITS data bits LSB first, optional parity,
// stop period. Bit timing counts sample_tick pulses from the shared baud
// tick generator; tx is a registered copy of the level the FSM selects.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBITS      = DEF_DBITS,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned SB_TICK    = DEF_SB_TICK,
  parameter int unsigned PARITY     = DEF_PARITY
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             tx_start,
  input  logic [DBITS-1:0] tx_data,
  output logic             tx_busy,
  output logic             tx_done_tick,
  output logic             tx
);

  localparam int unsigned TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam int unsigned BW   = $clog2(DBITS + 1);

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

  uart_state_t      state;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [DBITS-1:0] shreg;
  logic             par_acc;
  logic             tx_level;

  // Line level implied by the current state; registered into tx below
  always_comb begin
    tx_level = 1'b1;
    case (state)
      S_START:  tx_level = 1'b0;
      S_DATA:   tx_level = shreg[0];
      S_PARITY: tx_level = (PARITY == PAR_ODD) ? ~par_acc : par_acc;
      default:  tx_level = 1'b1;
    endcase
  end

  // Done is decoded from the live state so it coincides with the final stop
  // tick while the FSM still sits in STOP (a start in that cycle is ignored).
  assign tx_done_tick = (state == S_STOP) && sample_tick && (tick_cnt == SB_LAST);

  // Frame sequencer with registered tx/busy outputs
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      tx_busy  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_level;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            shreg    <= tx_data;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (sample_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (sample_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              shreg    <= shreg >> 1;
              par_acc  <= par_acc ^ shreg[0];
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (sample_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (sample_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt <= '0;
              tx_busy  <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          tx_busy  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (no parity, even, odd, two stop
// bits) share clock, reset and a sample_tick every 4 clocks.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] tx_data;
  logic [3:0] start_v;
  logic [3:0] tx_w, busy_w, done_w;
  logic [1:0] ph;
  int         ticks_seen;
  int         n_total, n_bad;
  int         base, guard;

  always #5 clk = ~clk;

  uart_tx u_none (
    .clk_100MHz(clk), .reset(reset), .sample_tick(tick), .tx_start(start_v[0]),
    .tx_data(tx_data), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));
  uart_tx #(.PARITY(PAR_EVEN)) u_even (
    .clk_100MHz(clk), .reset(reset), .sample_tick(tick), .tx_start(start_v[1]),
    .tx_data(tx_data), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));
  uart_tx #(.PARITY(PAR_ODD)) u_odd (
    .clk_100MHz(clk), .reset(reset), .sample_tick(tick), .tx_start(start_v[2]),
    .tx_data(tx_data), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));
  uart_tx #(.SB_TICK(32)) u_sb32 (
    .clk_100MHz(clk), .reset(reset), .sample_tick(tick), .tx_start(start_v[3]),
    .tx_data(tx_data), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled just after negedge
  task automatic step();
    logic cur;
    cur = tick;
    @(negedge clk);
    if (cur) ticks_seen++;
    tick = (ph == 2'd3);
    ph   = ph + 2'd1;
    #1;
  endtask

  // Send one frame on instance sel and check it tick by tick.
  // lv[i] is the expected line level of bit i (0 = start, then data, then
  // parity); nb bits precede a stop period of sb ticks. align: 0/1 forces the
  // tick at the accepting edge, 2 accepts immediately. poke_at >= 0 pulses a
  // second start (data FF) when that many ticks of the frame have elapsed.
  task automatic run_frame(input string tag, input int sel, input logic [7:0] d,
                           input logic [9:0] lv, input int nb, input int sb,
                           input int align, input bit hold, input int poke_at);
    int  k, errs, dones, kdone, total, g;
    bit  poked;
    logic e;
    total = nb * 16 + sb;
    if (align != 2) begin
      while (int'(tick) != align) step();
    end
    tx_data      = d;
    start_v[sel] = 1'b1;
    step();
    if (!hold) start_v[sel] = 1'b0;
    tx_data = ~d;
    check({tag, "_acc_busy"}, int'(busy_w[sel]), 1);
    check({tag, "_acc_tx"}, int'(tx_w[sel]), 1);
    base = ticks_seen;
    k = 0; errs = 0; dones = 0; kdone = -1; g = 0; poked = 1'b0;
    while (busy_w[sel] && g < 4000) begin
      if (done_w[sel]) begin
        dones++;
        kdone = k;
      end
      if (!hold) begin
        if (poke_at >= 0 && k >= poke_at && !poked) begin
          start_v[sel] = 1'b1;
          tx_data      = 8'hFF;
          poked        = 1'b1;
        end else begin
          start_v[sel] = 1'b0;
        end
      end
      step();
      // tx lags the FSM by one clock, so it shows the bit for the pre-step count
      e = (k / 16 < nb) ? lv[k / 16] : 1'b1;
      if (tx_w[sel] !== e) errs++;
      k = ticks_seen - base;
      g++;
    end
    if (!hold) start_v[sel] = 1'b0;
    check({tag, "_len_ticks"}, k, total);
    check({tag, "_done_cnt"}, dones, 1);
    check({tag, "_done_pos"}, kdone, total - 1);
    check({tag, "_tx_errs"}, errs, 0);
  endtask

  // Idle watch: no busy, no done, line high for n clocks
  task automatic watch_idle(input string tag, input int sel, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (busy_w[sel] || done_w[sel] || !tx_w[sel]) bad++;
    end
    check({tag, "_idle"}, bad, 0);
  endtask

  initial begin
    n_total = 0; n_bad = 0; ticks_seen = 0; ph = 2'd0;
    reset = 1'b1; tick = 1'b0; tx_data = 8'h00; start_v = 4'h0;
    repeat (8) step();
    check("rst_tx", int'(tx_w), 4'hF);
    check("rst_busy", int'(busy_w), 0);
    check("rst_done", int'(done_w), 0);
    reset = 1'b0;
    repeat (4) step();

    // A5: start 0, data 1,0,1,0,0,1,0,1 (LSB first) -> lv = i8..i0 = 101001010
    run_frame("a5", 0, 8'hA5, 10'b0101001010, 9, 16, 0, 1'b0, -1);
    watch_idle("a5_after", 0, 100);

    // 07 even: start 0, data 1,1,1,0,0,0,0,0, parity 1
    run_frame("par_even", 1, 8'h07, 10'b1000001110, 10, 16, 0, 1'b0, -1);
    // 07 odd: parity 0
    run_frame("par_odd", 2, 8'h07, 10'b0000001110, 10, 16, 0, 1'b0, -1);

    // Second start (FF) mid-frame is ignored; no second frame follows
    run_frame("busy_ign", 0, 8'hA5, 10'b0101001010, 9, 16, 0, 1'b0, 80);
    watch_idle("busy_ign", 0, 800);

    // Start held across done: next frame (3C) is accepted the cycle after done
    run_frame("hold_a", 0, 8'hA5, 10'b0101001010, 9, 16, 0, 1'b1, -1);
    // 3C: start 0, data 0,0,1,1,1,1,0,0
    run_frame("hold_b", 0, 8'h3C, 10'b0001111000, 9, 16, 2, 1'b0, -1);
    watch_idle("hold_b", 0, 50);

    // Back-to-back 00 then 55 with start raised the cycle after done
    run_frame("b2b_00", 0, 8'h00, 10'b0000000000, 9, 16, 1, 1'b0, -1);
    // 55: start 0, data 1,0,1,0,1,0,1,0
    run_frame("b2b_55", 0, 8'h55, 10'b0010101010, 9, 16, 2, 1'b0, -1);
    watch_idle("b2b_55", 0, 50);

    // Reset during data bit 3 of A5 (bit 3 = 0), then a clean 3C frame
    while (tick != 1'b0) step();
    tx_data = 8'hA5; start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    base = ticks_seen; guard = 0;
    while (ticks_seen - base < 70 && guard < 2000) begin
      step();
      guard++;
    end
    check("rst_mid_pre_tx", int'(tx_w[0]), 0);
    check("rst_mid_pre_busy", int'(busy_w[0]), 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_tx", int'(tx_w[0]), 1);
    check("rst_mid_busy", int'(busy_w[0]), 0);
    check("rst_mid_done", int'(done_w[0]), 0);
    repeat (3) step();
    reset = 1'b0;
    step();
    run_frame("post_rst_3c", 0, 8'h3C, 10'b0001111000, 9, 16, 0, 1'b0, -1);

    // Tick coincident with the accepting edge, default and 2-stop-bit instances
    run_frame("tick_acc", 0, 8'h3C, 10'b0001111000, 9, 16, 1, 1'b0, -1);
    run_frame("sb32", 3, 8'hA5, 10'b0101001010, 9, 32, 1, 1'b0, -1);
    watch_idle("sb32", 3, 50);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
